// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, demux state encoding and port count.
package axil_pkg;

   localparam int N_SLV = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      RESP,
      ERR_W,
      ERR_B
   } state_t;

endpackage

// File: rtl/binary_decoder_2to4.sv
// 2-to-4 binary-to-one-hot decoder with enable; all-zero output when disabled.
module binary_decoder_2to4
   import axil_pkg::*;
(
   input  logic             en,
   input  logic [1:0]       idx,
   output logic [N_SLV-1:0] sel
);

   // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
   always_comb begin
      sel = '0;
      if (en) sel[idx] = 1'b1;
   end

endmodule

// File: rtl/axil_wr_demux_1to4.sv
// AXI4-Lite write demux, one manager to four subordinates, one outstanding write.
// The top two address bits pick the subordinate; unmapped ones answer DECERR locally.
module axil_wr_demux_1to4
   import axil_pkg::*;
#(
   parameter int               ADDR_W = 32,
   parameter int               DATA_W = 32,
   parameter logic [N_SLV-1:0] SLV_EN = 4'b1111
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [2:0]          s_awprot,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [2:0]          m_awprot,
   output logic [N_SLV-1:0]    m_awvalid,
   input  logic [N_SLV-1:0]    m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic [N_SLV-1:0]    m_wvalid,
   input  logic [N_SLV-1:0]    m_wready,
   input  logic [2*N_SLV-1:0]  m_bresp,
   input  logic [N_SLV-1:0]    m_bvalid,
   output logic [N_SLV-1:0]    m_bready
);

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_in;
   logic [N_SLV-1:0] sel, sel_dec;
   logic             aw_done, w_done;
   logic             aw_accept, aw_fin, w_fin;

   assign idx_in    = s_awaddr[ADDR_W-1 -: 2];
   assign aw_accept = (state == IDLE) && s_awvalid;

   // A channel is finished once its handshake happened earlier or happens this cycle.
   assign aw_fin = aw_done | m_awready[idx];
   assign w_fin  = w_done  | (s_wvalid & m_wready[idx]);

   assign m_wdata = s_wdata;
   assign m_wstrb = s_wstrb;

   binary_decoder_2to4 u_dec (
      .en  (aw_accept),
      .idx (idx_in),
      .sel (sel_dec)
   );

   always_comb begin
      state_nxt = state;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_bresp   = RESP_OKAY;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      case (state)
         IDLE: begin
            s_awready = 1'b1;
            if (s_awvalid) state_nxt = SLV_EN[idx_in] ? FWD : ERR_W;
         end
         FWD: begin
            m_awvalid = sel & {N_SLV{~aw_done}};
            m_wvalid  = sel & {N_SLV{s_wvalid & ~w_done}};
            s_wready  = m_wready[idx] & ~w_done;
            if (aw_fin && w_fin) state_nxt = RESP;
         end
         RESP: begin
            m_bready = sel & {N_SLV{s_bready}};
            s_bvalid = m_bvalid[idx];
            s_bresp  = m_bresp[{idx, 1'b0} +: 2];
            if (s_bvalid && s_bready) state_nxt = IDLE;
         end
         ERR_W: begin
            s_wready = 1'b1;
            if (s_wvalid) state_nxt = ERR_B;
         end
         ERR_B: begin
            s_bvalid = 1'b1;
            s_bresp  = RESP_DECERR;
            if (s_bready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= IDLE;
         idx      <= '0;
         sel      <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         m_awaddr <= '0;
         m_awprot <= '0;
      end else begin
         state <= state_nxt;
         if (aw_accept) begin
            idx      <= idx_in;
            sel      <= sel_dec;
            m_awaddr <= s_awaddr;
            m_awprot <= s_awprot;
         end
         if (state == FWD && !(aw_fin && w_fin)) begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axil_wr_demux_1to4.sv
// Scoreboard bench for the AXI4-Lite write demux: driver pushes expectations, monitor pops on handshakes.
module tb_axil_wr_demux_1to4;

   typedef struct packed {
      logic [3:0]  vld;
      logic [31:0] addr;
      logic [2:0]  prot;
   } aw_exp_t;

   typedef struct packed {
      logic [3:0]  vld;
      logic [31:0] data;
      logic [3:0]  strb;
   } w_exp_t;

   logic        ACLK    = 1'b0;
   logic        ARESETN = 1'b0;

   logic [31:0] s_awaddr  = '0;
   logic [2:0]  s_awprot  = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata   = '0;
   logic [3:0]  s_wstrb   = '0;
   logic        s_wvalid  = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready  = 1'b0;
   logic [31:0] m_awaddr;
   logic [2:0]  m_awprot;
   logic [3:0]  m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [3:0]  m_wvalid, m_wready;
   logic [7:0]  m_bresp;
   logic [3:0]  m_bvalid, m_bready;

   logic [31:0] e_awaddr  = '0;
   logic [2:0]  e_awprot  = 3'b101;
   logic        e_awvalid = 1'b0;
   logic        e_awready;
   logic [31:0] e_wdata   = '0;
   logic [3:0]  e_wstrb   = '0;
   logic        e_wvalid  = 1'b0;
   logic        e_wready;
   logic [1:0]  e_bresp;
   logic        e_bvalid;
   logic        e_bready  = 1'b0;
   logic [31:0] e_m_awaddr;
   logic [2:0]  e_m_awprot;
   logic [3:0]  e_m_awvalid, e_m_wvalid, e_m_bready;
   logic [31:0] e_m_wdata;
   logic [3:0]  e_m_wstrb;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;
   int awv_cnt  = 0;
   int w_beats  = 0;
   int lat;

   aw_exp_t    exp_aw[$];
   w_exp_t     exp_w[$];
   logic [1:0] exp_b[$];
   logic [1:0] exp_eb[$];

   int         aw_stall[4];
   int         b_delay[4];
   logic [1:0] b_cfg[4];
   bit         aw_seen[4], w_seen[4], b_go[4];
   int         aw_cnt[4], b_cnt[4];

   axil_wr_demux_1to4 #(.ADDR_W(32), .DATA_W(32), .SLV_EN(4'b1111)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   axil_wr_demux_1to4 #(.ADDR_W(32), .DATA_W(32), .SLV_EN(4'b0111)) dut_err (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_awaddr(e_awaddr), .s_awprot(e_awprot), .s_awvalid(e_awvalid), .s_awready(e_awready),
      .s_wdata(e_wdata), .s_wstrb(e_wstrb), .s_wvalid(e_wvalid), .s_wready(e_wready),
      .s_bresp(e_bresp), .s_bvalid(e_bvalid), .s_bready(e_bready),
      .m_awaddr(e_m_awaddr), .m_awprot(e_m_awprot), .m_awvalid(e_m_awvalid), .m_awready(4'hF),
      .m_wdata(e_m_wdata), .m_wstrb(e_m_wstrb), .m_wvalid(e_m_wvalid), .m_wready(4'hF),
      .m_bresp(8'h00), .m_bvalid(4'h0), .m_bready(e_m_bready)
   );

   initial forever #5 ACLK = ~ACLK;
   initial forever begin
      @(posedge ACLK);
      cyc = cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, required finish earlier");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Subordinate model: AW stall counted per offered cycle, B issued b_delay cycles after AW+W.
   initial begin
      for (int i = 0; i < 4; i++) begin
         aw_stall[i] = 0; b_delay[i] = 0; b_cfg[i] = 2'b00;
      end
      m_awready = 4'hF; m_wready = 4'hF; m_bvalid = 4'h0; m_bresp = 8'h00;
      forever begin
         @(negedge ACLK);
         for (int i = 0; i < 4; i++) begin
            if (!ARESETN) begin
               aw_seen[i] = 0; w_seen[i] = 0; b_go[i] = 0; aw_cnt[i] = 0; b_cnt[i] = 0;
            end else begin
               if (m_awvalid[i] && m_awready[i]) begin
                  aw_seen[i] = 1; aw_cnt[i] = 0;
               end else if (m_awvalid[i]) aw_cnt[i]++;
               if (m_wvalid[i] && m_wready[i]) w_seen[i] = 1;
               if (m_bvalid[i] && m_bready[i]) begin
                  aw_seen[i] = 0; w_seen[i] = 0; b_go[i] = 0; b_cnt[i] = 0;
               end else if (aw_seen[i] && w_seen[i] && !b_go[i]) begin
                  if (b_cnt[i] >= b_delay[i]) b_go[i] = 1;
                  else b_cnt[i]++;
               end
            end
         end
         @(posedge ACLK);
         #1;
         for (int i = 0; i < 4; i++) begin
            m_awready[i]     = (aw_cnt[i] >= aw_stall[i]);
            m_bvalid[i]      = b_go[i];
            m_bresp[2*i +: 2] = b_cfg[i];
         end
      end
   end

   // Monitor: pops expectations whenever a handshake is observed.
   initial begin
      aw_exp_t ea;
      w_exp_t  ew;
      logic [1:0] eb;
      forever begin
         @(negedge ACLK);
         if (ARESETN) begin
            check("onehot_rule", {63'd0, $onehot0(m_awvalid) && $onehot0(m_wvalid) && $onehot0(m_bready)}, 64'd1);
            if (m_awvalid != 4'h0) awv_cnt++;
            if (s_wvalid && s_wready) w_beats++;
            if (|(m_awvalid & m_awready)) begin
               check("aw_expected", {63'd0, exp_aw.size() != 0}, 64'd1);
               if (exp_aw.size() != 0) begin
                  ea = exp_aw.pop_front();
                  check("aw_beat", {25'd0, m_awvalid, m_awaddr, m_awprot}, {25'd0, ea});
               end
            end
            if (|(m_wvalid & m_wready)) begin
               check("w_expected", {63'd0, exp_w.size() != 0}, 64'd1);
               if (exp_w.size() != 0) begin
                  ew = exp_w.pop_front();
                  check("w_beat", {24'd0, m_wvalid, m_wdata, m_wstrb}, {24'd0, ew});
               end
            end
            if (s_bvalid && s_bready) begin
               check("b_expected", {63'd0, exp_b.size() != 0}, 64'd1);
               if (exp_b.size() != 0) begin
                  eb = exp_b.pop_front();
                  check("b_resp", {62'd0, s_bresp}, {62'd0, eb});
               end
            end
            if (e_bvalid && e_bready) begin
               check("eb_expected", {63'd0, exp_eb.size() != 0}, 64'd1);
               if (exp_eb.size() != 0) begin
                  eb = exp_eb.pop_front();
                  check("eb_resp", {62'd0, e_bresp}, {62'd0, eb});
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s"}, {59'd0, s_awready, s_wready, s_bvalid, s_bresp}, {59'd0, 5'b10000});
      check({tag, "_mvld"}, {52'd0, m_awvalid, m_wvalid, m_bready}, 64'd0);
      check({tag, "_maddr"}, {29'd0, m_awaddr, m_awprot}, 64'd0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold, input logic [3:0] exp_vld,
                           input logic [1:0] exp_bresp, output int latency);
      int  t_aw = 0;
      int  t_b  = 0;
      int  hold = 0;
      bit  aw_ok = 0;
      bit  w_ok  = 0;
      bit  b_ok  = 0;
      exp_aw.push_back({exp_vld, addr, data[2:0]});
      exp_w.push_back({exp_vld, data, strb});
      exp_b.push_back(exp_bresp);
      s_wdata = data;
      s_wstrb = strb;
      if (w_lead > 0) begin
         s_wvalid = 1'b1;
         for (int k = 0; k < w_lead; k++) begin
            @(negedge ACLK);
            check("wready_idle", {63'd0, s_wready}, 64'd0);
            @(posedge ACLK);
            #1;
         end
      end
      s_awaddr = addr;
      s_awprot = data[2:0];
      fork
         begin
            s_awvalid = 1'b1;
            for (int k = 0; k < 64 && !aw_ok; k++) begin
               @(negedge ACLK);
               if (s_awready) begin
                  aw_ok = 1; t_aw = cyc;
               end
               @(posedge ACLK);
               #1;
            end
            s_awvalid = 1'b0;
         end
         begin
            s_wvalid = 1'b1;
            for (int k = 0; k < 64 && !w_ok; k++) begin
               @(negedge ACLK);
               if (s_wready) w_ok = 1;
               @(posedge ACLK);
               #1;
            end
            s_wvalid = 1'b0;
         end
      join
      check("aw_accepted", {63'd0, aw_ok}, 64'd1);
      check("w_accepted", {63'd0, w_ok}, 64'd1);
      s_bready = (b_hold == 0);
      for (int k = 0; k < 64; k++) begin
         @(negedge ACLK);
         if (s_bvalid && s_bready) begin
            b_ok = 1; t_b = cyc;
            break;
         end
         if (s_bvalid) begin
            check("bresp_stable", {62'd0, s_bresp}, {62'd0, exp_bresp});
            hold++;
         end
         @(posedge ACLK);
         #1;
         if (hold >= b_hold) s_bready = 1'b1;
      end
      check("b_received", {63'd0, b_ok}, 64'd1);
      @(posedge ACLK);
      #1;
      s_bready = 1'b0;
      latency = t_b - t_aw;
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge ACLK);
      check_reset_outputs("reset");
      #2 ARESETN = 1'b1;
      @(posedge ACLK);
      #1;

      // Mapped write to subordinate 2, all ready: 3-cycle transaction.
      awv_cnt = 0;
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 4'b0100, 2'b00, lat);
      check("latency_min", lat, 64'd2);
      check("awvalid_cycles_fast", awv_cnt, 64'd1);

      // W offered two cycles before AW, subordinate 3 (top quarter).
      w_beats = 0;
      do_write(32'hC000_0000, 32'h0BAD_F00D, 4'b1010, 2, 0, 4'b1000, 2'b00, lat);
      check("w_beats_once", w_beats, 64'd1);

      // AW stall, delayed SLVERR response and manager backpressure on B.
      aw_stall[1] = 4; b_delay[1] = 3; b_cfg[1] = axil_pkg::RESP_SLVERR;
      awv_cnt = 0;
      do_write(32'h4000_0020, 32'h1234_5678, 4'b0011, 0, 2, 4'b0010, 2'b10, lat);
      check("awvalid_cycles_stall", awv_cnt, 64'd5);
      aw_stall[1] = 0; b_delay[1] = 0; b_cfg[1] = axil_pkg::RESP_OKAY;

      // DECERR on an unmapped subordinate (separate instance with index 3 disabled).
      exp_eb.push_back(axil_pkg::RESP_DECERR);
      e_awaddr = 32'hF000_0000; e_wdata = 32'hA5A5_5A5A; e_wstrb = 4'hF;
      e_awvalid = 1'b1; e_wvalid = 1'b1;
      @(negedge ACLK);
      check("err_idle", {62'd0, e_awready, e_wready}, 64'b10);
      @(posedge ACLK);
      #1 e_awvalid = 1'b0;
      @(negedge ACLK);
      check("err_w_sink", {62'd0, e_wready, e_bvalid}, 64'b10);
      check("err_w_quiet", {52'd0, e_m_awvalid, e_m_wvalid, e_m_bready}, 64'd0);
      check("err_awcopy", {29'd0, e_m_awaddr, e_m_awprot}, {29'd0, 32'hF000_0000, 3'b101});
      check("err_wpass", {28'd0, e_m_wdata, e_m_wstrb}, {28'd0, 32'hA5A5_5A5A, 4'hF});
      @(posedge ACLK);
      #1 e_wvalid = 1'b0;
      @(negedge ACLK);
      check("err_b", {61'd0, e_bvalid, e_bresp}, {61'd0, 3'b111});
      check("err_b_quiet", {51'd0, e_awready, e_m_awvalid, e_m_wvalid, e_m_bready}, 64'd0);
      @(posedge ACLK);
      #1 e_bready = 1'b1;
      @(negedge ACLK);
      @(posedge ACLK);
      #1 e_bready = 1'b0;
      @(negedge ACLK);
      check("err_back_idle", {62'd0, e_awready, e_bvalid}, 64'b10);

      // Reset while subordinate 0 is stalling AW in FWD.
      aw_stall[0] = 50;
      @(posedge ACLK);
      #1;
      s_awaddr = 32'h0000_0040; s_awprot = 3'b011; s_awvalid = 1'b1;
      @(posedge ACLK);
      #1 s_awvalid = 1'b0;
      @(negedge ACLK);
      check("pre_reset_fwd", {60'd0, m_awvalid}, 64'b0001);
      #2 ARESETN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      aw_stall[0] = 0;
      @(negedge ACLK);
      #2 ARESETN = 1'b1;
      @(negedge ACLK);
      check("post_reset", {59'd0, s_awready, m_awvalid}, {59'd0, 5'b10000});
      @(posedge ACLK);
      #1;

      // Back-to-back writes to subordinates 0, 3, 2.
      b_cfg[3] = 2'b01;
      do_write(32'h0000_0100, 32'h1111_0001, 4'b0001, 0, 0, 4'b0001, 2'b00, lat);
      do_write(32'hC000_0200, 32'h2222_0002, 4'b1100, 0, 0, 4'b1000, 2'b01, lat);
      do_write(32'h8000_0300, 32'h3333_0003, 4'b1111, 0, 0, 4'b0100, 2'b00, lat);

      repeat (2) @(negedge ACLK);
      check("queues_drained", exp_aw.size() + exp_w.size() + exp_b.size() + exp_eb.size(), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
